truth_table_checker: RTL and testbench

Self-checking stimulus sequencer that sits directly upstream and downstream of a small combinational primitive under test, such as a gate-level and a UDP-table implementation of the same function. It sweeps every input combination, holds each vector for a programmable number of cycles, and compares the DUT output against a reference output. It reports the mismatch count, the first failing vector and a pass/fail verdict, which replaces hand-written delay-and-monitor benches.

---
 rtl/truth_table_checker.sv | 170 +++++++++++++++++
 tb/tb_truth_table_checker.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// truth_table_checker
// Sweeps every N_IN-bit input vector into a combinational primitive and its
// reference, holds each vector for HOLD_CYCLES clocks, then compares the two
// outputs once at the end of the hold window. Reports a mismatch count, the
// first failing vector and a pass/fail verdict for the completed sweep.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          launch a sweep (only honoured in IDLE)
//   stim           vector driven to DUT and reference inputs
//   dut_y, ref_y   DUT output and reference output
//   busy           high while a sweep is running
//   done           one-cycle pulse at end of sweep
//   pass           verdict of the last completed sweep
//   mismatch       one-cycle pulse after each failing compare
//   err_count      mismatches in current or last sweep (saturating)
//   vec_count      vectors compared in current or last sweep
//   first_fail_vec stim value of the first mismatch
//
// state | meaning
// IDLE  | waiting for start; results of last sweep held
// DRIVE | holding stim, comparing at the end of each hold window
// DONE  | single cycle: done pulse, verdict published

module truth_table_checker #(
    parameter int N_IN        = 2,
    parameter int HOLD_CYCLES = 20,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  stim,
    input  logic             dut_y,
    input  logic             ref_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [N_IN-1:0]  first_fail_vec
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0]   STIM_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              mismatch_q, mismatch_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [CNT_W-1:0]  vec_count_q, vec_count_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              miss;

    // Case inequality so that an X or Z from the DUT is treated as a failure.
    assign miss = (dut_y !== ref_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stim_q      <= '0;
            hold_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            err_count_q <= '0;
            vec_count_q <= '0;
            ffv_q       <= '0;
        end else begin
            state_q     <= state_d;
            stim_q      <= stim_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            mismatch_q  <= mismatch_d;
            err_count_q <= err_count_d;
            vec_count_q <= vec_count_d;
            ffv_q       <= ffv_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stim_d      = stim_q;
        hold_d      = hold_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        mismatch_d  = 1'b0;
        err_count_d = err_count_q;
        vec_count_d = vec_count_q;
        ffv_d       = ffv_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = DRIVE;
                    stim_d      = '0;
                    hold_d      = '0;
                    err_count_d = '0;
                    vec_count_d = '0;
                    ffv_d       = '0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                end
            end

            DRIVE: begin
                if (hold_q == HOLD_LAST) begin
                    vec_count_d = vec_count_q + 1'b1;
                    if (miss) begin
                        mismatch_d = 1'b1;
                        if (err_count_q != {CNT_W{1'b1}}) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (err_count_q == '0) begin
                            ffv_d = stim_q;
                        end
                    end
                    if (stim_q == STIM_LAST) begin
                        // Verdict uses the count including this last compare.
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_count_d == '0);
                    end else begin
                        stim_d = stim_q + 1'b1;
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign stim           = stim_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign mismatch       = mismatch_q;
    assign err_count      = err_count_q;
    assign vec_count      = vec_count_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

    localparam int N_IN  = 2;
    localparam int HOLD  = 4;
    localparam int CNT_W = 8;
    localparam int NVEC  = 1 << N_IN;
    localparam int SWEEP = NVEC * HOLD;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [N_IN-1:0]  stim;
    logic             dut_y;
    logic             ref_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic             mismatch;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] vec_count;
    logic [N_IN-1:0]  first_fail_vec;

    logic [NVEC-1:0]  fault_mask;

    int checks = 0;
    int errors = 0;

    truth_table_checker #(
        .N_IN(N_IN), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim),
        .dut_y(dut_y), .ref_y(ref_y), .busy(busy), .done(done),
        .pass(pass), .mismatch(mismatch), .err_count(err_count),
        .vec_count(vec_count), .first_fail_vec(first_fail_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Primitive under test: an AND gate, with selected vectors corrupted.
    always_comb begin
        ref_y = &stim;
        dut_y = fault_mask[stim] ? ~ref_y : ref_y;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_stim"}, 32'(stim), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_mism"}, 32'(mismatch), 0);
        chk({tag, "_err"}, 32'(err_count), 0);
        chk({tag, "_vec"}, 32'(vec_count), 0);
        chk({tag, "_ffv"}, 32'(first_fail_vec), 0);
    endtask

    // Runs one sweep with the given fault set. Optional extra start pulse at
    // cycle pulse_at and asynchronous reset at cycle abort_at (0 = unused).
    task automatic run_sweep(input logic [NVEC-1:0] mask, input int pulse_at, input int abort_at);
        int exp_err, exp_ffv, pulses, cyc;
        bit found;
        exp_err = 0; exp_ffv = 0; found = 0; pulses = 0;
        for (int v = 0; v < NVEC; v++) begin
            if (mask[v]) begin
                exp_err++;
                if (!found) begin exp_ffv = v; found = 1; end
            end
        end
        fault_mask = mask;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);            // edge E0
        @(negedge clk);
        start = 1'b0;
        chk("launch_busy", 32'(busy), 1);
        chk("launch_stim", 32'(stim), 0);
        chk("launch_err", 32'(err_count), 0);

        for (cyc = 1; cyc <= SWEEP + 1; cyc++) begin
            start = (pulse_at != 0 && cyc == pulse_at) ? 1'b1 : 1'b0;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (abort_at != 0 && cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_idle_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (mismatch) pulses++;
            if (cyc <= SWEEP) begin
                chk("stim_seq", 32'(stim), (cyc < SWEEP) ? cyc / HOLD : NVEC - 1);
                chk("vec_seq", 32'(vec_count), cyc / HOLD);
                chk("busy_seq", 32'(busy), (cyc < SWEEP) ? 1 : 0);
                chk("done_seq", 32'(done), (cyc == SWEEP) ? 1 : 0);
                chk("mism_seq", 32'(mismatch),
                    (cyc % HOLD == 0 && mask[cyc / HOLD - 1]) ? 1 : 0);
            end
        end
        // One cycle after DONE: back in IDLE with results held.
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("err_count", 32'(err_count), exp_err);
        chk("vec_count", 32'(vec_count), NVEC);
        chk("first_fail", 32'(first_fail_vec), exp_ffv);
        chk("pass", 32'(pass), (exp_err == 0) ? 1 : 0);
        chk("pulse_cnt", pulses, exp_err);
        repeat (3) @(negedge clk);
        chk("hold_err", 32'(err_count), exp_err);
        chk("hold_pass", 32'(pass), (exp_err == 0) ? 1 : 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fault_mask = '0;
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_zero("post_reset");

        run_sweep(4'b0000, 0, 0);    // clean sweep
        run_sweep(4'b0100, 0, 0);    // stim=2 only
        run_sweep(4'b1111, 0, 0);    // all inverted
        run_sweep(4'b0010, 0, 0);    // stim=1 only
        run_sweep(4'b1010, 6, 0);    // extra start mid-sweep ignored
        run_sweep(4'b0000, 0, 0);    // rerun clears counters
        run_sweep(4'b0110, 0, 9);    // reset mid-sweep
        chk_idle_zero("after_abort");
        run_sweep(4'b0000, 0, 0);

        for (int r = 0; r < 8; r++) begin
            run_sweep(NVEC'($urandom_range(0, NVEC * 2 - 1)), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
